// File: rtl/jdequant_zz.sv
// rtl/jdequant_zz.sv - JPEG inverse quantization with saturating multiply and block-boundary table reload
module jdequant_zz #(
    parameter int DW    = 16,
    parameter int QW    = 8,
    parameter int NCOEF = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] in_d,
    input  logic          in_v,
    output logic          in_b,
    input  logic [QW-1:0] qtab_d,
    input  logic          qtab_v,
    output logic          qtab_b,
    output logic [DW-1:0] out_d,
    output logic          out_v,
    input  logic          out_b,
    output logic          blk_done
);

    localparam int IW = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int PW = DW + QW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);
    localparam logic [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IW-1:0] tidx;
    logic [IW-1:0] cidx;
    logic [QW-1:0] qtab_mem [NCOEF];

    logic in_acc;
    logic qtab_acc;
    logic out_take;

    logic signed [PW-1:0] coef_ext;
    logic signed [PW-1:0] scale_ext;
    logic signed [PW-1:0] prod;
    logic                 prod_fits;
    logic [DW-1:0]        prod_sat;

    assign in_acc   = in_v && !in_b;
    assign qtab_acc = qtab_v && !qtab_b;
    assign out_take = out_v && !out_b;

    // Next state and stream backpressure; a reload request at a block boundary stalls input
    always_comb begin
        state_nxt = state;
        in_b      = 1'b1;
        qtab_b    = 1'b1;
        case (state)
            ST_LOAD: begin
                qtab_b = 1'b0;
                if (qtab_acc && (tidx == LAST_IDX)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                in_b = (out_v && out_b) || ((cidx == '0) && qtab_v);
                if ((cidx == '0) && qtab_v) begin
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // State register; reset always forces a fresh table load
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Table storage, written only in LOAD; contents survive reset
    always_ff @(posedge clock) begin
        if (qtab_acc) begin
            qtab_mem[tidx] <= qtab_d;
        end
    end

    // Table write index and coefficient position within the current block
    always_ff @(posedge clock) begin
        if (reset) begin
            tidx <= '0;
            cidx <= '0;
        end else begin
            if (qtab_acc) begin
                if (tidx == LAST_IDX) begin
                    tidx <= '0;
                    cidx <= '0;
                end else begin
                    tidx <= tidx + 1'b1;
                end
            end
            if (in_acc) begin
                cidx <= (cidx == LAST_IDX) ? '0 : cidx + 1'b1;
            end
        end
    end

    // Signed coefficient times unsigned table entry, clamped to the DW-bit signed range
    always_comb begin
        coef_ext  = {{(QW+1){in_d[DW-1]}}, in_d};
        scale_ext = {{(DW+1){1'b0}}, qtab_mem[cidx]};
        prod      = coef_ext * scale_ext;
        prod_fits = (&prod[PW-1:DW-1]) || !(|prod[PW-1:DW-1]);
        if (prod_fits) begin
            prod_sat = prod[DW-1:0];
        end else if (prod[PW-1]) begin
            prod_sat = SAT_MIN;
        end else begin
            prod_sat = SAT_MAX;
        end
    end

    // Output register and end-of-block pulse; holds while the consumer stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            out_v    <= 1'b0;
            out_d    <= '0;
            blk_done <= 1'b0;
        end else begin
            blk_done <= in_acc && (cidx == LAST_IDX);
            if (in_acc) begin
                out_d <= prod_sat;
                out_v <= 1'b1;
            end else if (out_take) begin
                out_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jdequant_zz.sv
// tb/tb_jdequant_zz.sv - directed and random bench for jdequant_zz against a behavioural model
module tb_jdequant_zz;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_d = '0;
    logic        in_v = 1'b0;
    logic        in_b;
    logic [7:0]  qtab_d = '0;
    logic        qtab_v = 1'b0;
    logic        qtab_b;
    logic [15:0] out_d;
    logic        out_v;
    logic        out_b = 1'b0;
    logic        blk_done;

    jdequant_zz #(.DW(16), .QW(8), .NCOEF(64)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_d     (in_d),
        .in_v     (in_v),
        .in_b     (in_b),
        .qtab_d   (qtab_d),
        .qtab_v   (qtab_v),
        .qtab_b   (qtab_b),
        .out_d    (out_d),
        .out_v    (out_v),
        .out_b    (out_b),
        .blk_done (blk_done)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mtab [64];
    logic [7:0]  tab_buf [64];
    int          midx = 0;
    int          mtidx = 0;
    int          mdone = 0;
    int          done_cnt = 0;
    logic [15:0] expq [$];
    logic [15:0] out_hist [$];
    logic        exp_done = 1'b0;
    logic        exp_out_next = 1'b0;
    logic        hold_prev = 1'b0;
    logic [15:0] prev_d = '0;
    logic        last_in_acc = 1'b0;
    logic        last_q_acc = 1'b0;
    logic        obs_in_b = 1'b0;
    logic        obs_qtab_b = 1'b0;
    int          tries;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] deq(input logic [15:0] c, input logic [7:0] q);
        int p;
        p = int'($signed(c)) * int'(q);
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    // One clock: observe at negedge, update the model, then step past the rising edge
    task automatic cycle();
        @(negedge clock);
        last_in_acc = 1'b0;
        last_q_acc  = 1'b0;
        obs_in_b    = in_b;
        obs_qtab_b  = qtab_b;
        if (!reset) begin
            check("blk_done", blk_done, exp_done);
            if (exp_out_next) check("out_latency", out_v, 1);
            if (hold_prev) begin
                check("hold_out_v", out_v, 1);
                check("hold_out_d", out_d, prev_d);
            end
            if (out_v === 1'b1) begin
                check("out_expected", expq.size() > 0, 1);
                if (out_b == 1'b0 && expq.size() > 0) begin
                    check("out_d", out_d, expq.pop_front());
                    out_hist.push_back(out_d);
                end
            end
            if (blk_done === 1'b1) done_cnt++;
            exp_done = 1'b0;
            if (in_v && !in_b) begin
                last_in_acc = 1'b1;
                expq.push_back(deq(in_d, mtab[midx]));
                if (midx == 63) begin
                    exp_done = 1'b1;
                    mdone++;
                end
                midx = (midx + 1) % 64;
            end
            if (qtab_v && !qtab_b) begin
                last_q_acc = 1'b1;
                mtab[mtidx] = qtab_d;
                mtidx = (mtidx + 1) % 64;
                if (mtidx == 0) midx = 0;
            end
            exp_out_next = last_in_acc;
            hold_prev    = (out_v === 1'b1) && (out_b === 1'b1);
            prev_d       = out_d;
        end
        @(posedge clock);
        if (reset) begin
            expq.delete();
            midx = 0;
            mtidx = 0;
            exp_done = 1'b0;
            exp_out_next = 1'b0;
            hold_prev = 1'b0;
        end
        #1;
    endtask

    task automatic send_coef(input logic [15:0] c, output int n);
        in_v = 1'b1;
        in_d = c;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_in_acc && n < 200);
        if (!last_in_acc) check("send_timeout", 0, 1);
        in_v = 1'b0;
    endtask

    task automatic load_table();
        int n;
        for (int i = 0; i < 64; i++) begin
            qtab_v = 1'b1;
            qtab_d = tab_buf[i];
            n = 0;
            do begin
                cycle();
                n++;
            end while (!last_q_acc && n < 200);
            if (!last_q_acc) check("load_timeout", 0, 1);
        end
        qtab_v = 1'b0;
    endtask

    task automatic drain();
        in_v   = 1'b0;
        qtab_v = 1'b0;
        out_b  = 1'b0;
        repeat (3) cycle();
        check("drained", expq.size(), 0);
    endtask

    function automatic logic [15:0] rnd_coef();
        if ($urandom % 2 == 1) return 16'($urandom);
        return 16'(int'($urandom_range(0, 400)) - 200);
    endfunction

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        check("rst_out_v", out_v, 0);
        check("rst_out_d", out_d, 0);
        check("rst_blk_done", blk_done, 0);
        check("rst_qtab_b", qtab_b, 0);
        check("rst_in_b", in_b, 1);

        // Coefficients without a table are held off
        in_v = 1'b1;
        in_d = 16'd7;
        repeat (5) begin
            cycle();
            check("no_table_in_b", obs_in_b, 1);
        end
        in_v = 1'b0;

        // Unity table, ramp 0..63 at full rate
        for (int i = 0; i < 64; i++) tab_buf[i] = 8'd1;
        load_table();
        out_hist.delete();
        done_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            send_coef(16'(i), tries);
            check("no_bubble", tries, 1);
        end
        drain();
        check("ramp_count", out_hist.size(), 64);
        check("ramp_last", out_hist[63], 63);
        check("ramp_blk_done", done_cnt, 1);

        // Saturation and zero entry
        for (int i = 0; i < 64; i++) tab_buf[i] = 8'($urandom_range(1, 255));
        tab_buf[5] = 8'd16;
        tab_buf[6] = 8'd0;
        load_table();
        out_hist.delete();
        for (int i = 0; i < 64; i++) begin
            send_coef((i == 5) ? 16'd3000 : (i == 6) ? 16'd12345 : rnd_coef(), tries);
        end
        drain();
        check("sat_pos", out_hist[5], 16'h7fff);
        check("zero_entry", out_hist[6], 16'h0000);
        out_hist.delete();
        for (int i = 0; i < 64; i++) begin
            send_coef((i == 5) ? 16'hf448 : rnd_coef(), tries);
        end
        drain();
        check("sat_neg", out_hist[5], 16'h8000);

        // Consumer stall for 4 cycles mid-block on a ramp
        out_hist.delete();
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin
                out_b = 1'b1;
                in_v  = 1'b1;
                in_d  = 16'd10;
                repeat (4) begin
                    cycle();
                    check("stall_in_b", obs_in_b, 1);
                    check("stall_no_accept", last_in_acc, 0);
                end
                out_b = 1'b0;
            end
            send_coef(16'(i), tries);
        end
        drain();
        check("stall_count", out_hist.size(), 64);
        check("stall_idx10", out_hist[10], 16'(10 * int'(tab_buf[10])));
        check("stall_idx11", out_hist[11], 16'(11 * int'(tab_buf[11])));

        // Table request mid-block waits for the block boundary
        for (int i = 0; i < 20; i++) send_coef(rnd_coef(), tries);
        for (int i = 0; i < 64; i++) tab_buf[i] = 8'($urandom_range(0, 255));
        tab_buf[0] = 8'd20;
        tab_buf[1] = 8'd3;
        qtab_v = 1'b1;
        qtab_d = tab_buf[0];
        for (int i = 20; i < 64; i++) begin
            send_coef(rnd_coef(), tries);
            if (i < 24) begin
                check("midblk_qtab_b", obs_qtab_b, 1);
                check("midblk_no_load", last_q_acc, 0);
            end
        end
        in_v = 1'b1;
        in_d = 16'd1000;
        cycle();
        check("boundary_in_b", obs_in_b, 1);
        check("boundary_no_load", last_q_acc, 0);
        load_table();
        out_hist.delete();
        send_coef(16'd1000, tries);
        send_coef(16'hfff9, tries);
        for (int i = 2; i < 64; i++) send_coef(rnd_coef(), tries);
        drain();
        check("newtab_idx0", out_hist[0], 16'd20000);
        check("newtab_idx1", out_hist[1], 16'hffeb);

        // Reset in the middle of a block with a pending output
        for (int i = 0; i < 30; i++) send_coef(rnd_coef(), tries);
        check("pre_rst_out_v", out_v, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_rst_out_v", out_v, 0);
        check("mid_rst_qtab_b", qtab_b, 0);
        check("mid_rst_in_b", in_b, 1);
        for (int i = 0; i < 64; i++) tab_buf[i] = 8'($urandom_range(0, 255));
        tab_buf[0] = 8'd2;
        load_table();
        out_hist.delete();
        done_cnt = 0;
        send_coef(16'd100, tries);
        for (int i = 1; i < 64; i++) send_coef(rnd_coef(), tries);
        drain();
        check("post_rst_idx0", out_hist[0], 16'd200);
        check("post_rst_count", out_hist.size(), 64);
        check("post_rst_blk_done", done_cnt, 1);

        // Random gaps on all three streams over 10 blocks
        done_cnt = 0;
        mdone = 0;
        for (int cyc = 0; cyc < 20000 && mdone < 10; cyc++) begin
            in_v   = ($urandom % 4) != 0;
            in_d   = rnd_coef();
            out_b  = ($urandom % 3) == 0;
            qtab_v = ($urandom % 6) == 0;
            qtab_d = 8'($urandom);
            cycle();
        end
        drain();
        check("rand_model_blocks", mdone, 10);
        check("rand_blk_done", done_cnt, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
